// File: rtl/sram_bus_arbiter_if.sv
// Bus bundle for the arbiter: two upstream SRAM-style request channels
// (instruction fetch, data access), one downstream memory port and busy.
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding environment, which is the CPU core plus the memory bridge.
interface sram_bus_arbiter_if #(
    parameter int ADDR_W = 32
);
    // instruction fetch channel
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [31:0]       inst_rdata;
    // data access channel
    logic              data_req;
    logic              data_wr;
    logic [3:0]        data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;
    // downstream memory port
    logic              mem_req;
    logic              mem_wr;
    logic [3:0]        mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [31:0]       mem_rdata;
    logic              busy;

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output busy
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  busy
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Single-outstanding arbiter sharing one memory port between the fetch and
// data channels. Data wins ties, except when fetch has been passed over
// STARVE_LIMIT times in a row.
module sram_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input logic               clk,
    input logic               resetn,
    sram_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t            state, stateNext;
    logic              grantInst, grantData, memDone;
    logic              ownerInst;
    logic [ADDR_W-1:0] reqAddr;
    logic              reqWr;
    logic [3:0]        reqWstrb;
    logic [31:0]       reqWdata;
    logic [3:0]        starveCnt;
    logic              starveHit;
    logic              instDataOk, dataDataOk;
    logic [31:0]       instRdata, dataRdata;

    assign starveHit = (starveCnt == 4'(STARVE_LIMIT));

    // state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= stateNext;
    end

    // arbitration, downstream handshake and next-state decode
    always_comb begin
        stateNext = state;
        grantInst = 1'b0;
        grantData = 1'b0;
        memDone   = 1'b0;
        case (state)
            IDLE: begin
                // Gated by resetn so that no addr_ok leaks out while in reset.
                if (resetn) begin
                    if (bus.data_req && !(bus.inst_req && starveHit)) grantData = 1'b1;
                    else if (bus.inst_req)                              grantInst = 1'b1;
                end
                if (grantInst || grantData) stateNext = ADDR;
            end
            ADDR: begin
                if (bus.mem_addr_ok) begin
                    // Accept and response in the same cycle completes at once.
                    if (bus.mem_data_ok) begin
                        memDone   = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        stateNext = DATA;
                    end
                end
            end
            DATA: begin
                if (bus.mem_data_ok) begin
                    memDone   = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // request latch, starvation counter, response capture and data_ok pulses
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ownerInst  <= 1'b0;
            reqAddr    <= '0;
            reqWr      <= 1'b0;
            reqWstrb   <= 4'h0;
            reqWdata   <= 32'h0;
            starveCnt  <= 4'h0;
            instDataOk <= 1'b0;
            dataDataOk <= 1'b0;
            instRdata  <= 32'h0;
            dataRdata  <= 32'h0;
        end else begin
            instDataOk <= memDone && ownerInst;
            dataDataOk <= memDone && !ownerInst;
            if (grantInst || grantData) begin
                ownerInst <= grantInst;
                reqAddr   <= grantInst ? bus.inst_addr : bus.data_addr;
                reqWr     <= grantData && bus.data_wr;
                reqWstrb  <= (grantData && bus.data_wr) ? bus.data_wstrb : 4'h0;
                reqWdata  <= grantData ? bus.data_wdata : 32'h0;
            end
            // Fetch starvation only accumulates while a fetch is actually waiting.
            if (grantInst) begin
                starveCnt <= 4'h0;
            end else if (grantData) begin
                if (!bus.inst_req)   starveCnt <= 4'h0;
                else if (!starveHit) starveCnt <= starveCnt + 4'h1;
            end
            // A completed write leaves data_rdata untouched.
            if (memDone && ownerInst)           instRdata <= bus.mem_rdata;
            if (memDone && !ownerInst && !reqWr) dataRdata <= bus.mem_rdata;
        end
    end

    assign bus.inst_addr_ok = grantInst;
    assign bus.data_addr_ok = grantData;
    assign bus.inst_data_ok = instDataOk;
    assign bus.data_data_ok = dataDataOk;
    assign bus.inst_rdata   = instRdata;
    assign bus.data_rdata   = dataRdata;
    assign bus.mem_req      = (state == ADDR);
    assign bus.mem_wr       = reqWr;
    assign bus.mem_wstrb    = reqWstrb;
    assign bus.mem_addr     = reqAddr;
    assign bus.mem_wdata    = reqWdata;
    assign bus.busy         = (state != IDLE);
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: a per-cycle vector table followed by
// hand-written starvation and reset-in-flight sequences.
module tb_sram_bus_arbiter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter_if #(.ADDR_W(32)) bus ();

    sram_bus_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32)) dut (
        .clk(clk), .resetn(resetn), .bus(bus.slave)
    );

    typedef struct {
        string       nm;
        logic        ir;  logic [31:0] ia;
        logic        dr;  logic dw; logic [3:0] ds; logic [31:0] da; logic [31:0] dd;
        logic        mao; logic mdo; logic [31:0] mr;
        logic        eIa; logic eDa; logic eId; logic eDd;
        logic        eMr; logic eMw; logic [3:0] eMs; logic [31:0] eMa; logic [31:0] eMd;
        logic        eB;  logic [31:0] eIr; logic [31:0] eDr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm,
        logic ir, logic [31:0] ia, logic dr, logic dw, logic [3:0] ds, logic [31:0] da, logic [31:0] dd,
        logic mao, logic mdo, logic [31:0] mr,
        logic eIa, logic eDa, logic eId, logic eDd,
        logic eMr, logic eMw, logic [3:0] eMs, logic [31:0] eMa, logic [31:0] eMd,
        logic eB, logic [31:0] eIr, logic [31:0] eDr);
        vec_t v;
        v.nm = nm; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.ds = ds; v.da = da; v.dd = dd;
        v.mao = mao; v.mdo = mdo; v.mr = mr;
        v.eIa = eIa; v.eDa = eDa; v.eId = eId; v.eDd = eDd;
        v.eMr = eMr; v.eMw = eMw; v.eMs = eMs; v.eMa = eMa; v.eMd = eMd;
        v.eB = eB; v.eIr = eIr; v.eDr = eDr;
        return v;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(logic ir, logic [31:0] ia, logic dr, logic dw, logic [3:0] ds,
                         logic [31:0] da, logic [31:0] dd, logic mao, logic mdo, logic [31:0] mr);
        bus.inst_req = ir;  bus.inst_addr = ia;
        bus.data_req = dr;  bus.data_wr = dw; bus.data_wstrb = ds;
        bus.data_addr = da; bus.data_wdata = dd;
        bus.mem_addr_ok = mao; bus.mem_data_ok = mdo; bus.mem_rdata = mr;
    endtask

    task automatic checkAllZero(string nm);
        check(nm, 32'(|{bus.inst_addr_ok, bus.inst_data_ok, bus.inst_rdata,
                        bus.data_addr_ok, bus.data_data_ok, bus.data_rdata,
                        bus.mem_req, bus.mem_wr, bus.mem_wstrb, bus.mem_addr,
                        bus.mem_wdata, bus.busy}), 32'h0);
    endtask

    task automatic applyRow(vec_t v);
        @(posedge clk); #1;
        drive(v.ir, v.ia, v.dr, v.dw, v.ds, v.da, v.dd, v.mao, v.mdo, v.mr);
        @(negedge clk);
        check({v.nm, ".inst_addr_ok"}, 32'(bus.inst_addr_ok), 32'(v.eIa));
        check({v.nm, ".data_addr_ok"}, 32'(bus.data_addr_ok), 32'(v.eDa));
        check({v.nm, ".inst_data_ok"}, 32'(bus.inst_data_ok), 32'(v.eId));
        check({v.nm, ".data_data_ok"}, 32'(bus.data_data_ok), 32'(v.eDd));
        check({v.nm, ".mem_req"},      32'(bus.mem_req),      32'(v.eMr));
        check({v.nm, ".busy"},         32'(bus.busy),         32'(v.eB));
        check({v.nm, ".inst_rdata"},   bus.inst_rdata,        v.eIr);
        check({v.nm, ".data_rdata"},   bus.data_rdata,        v.eDr);
        // Downstream request fields only matter while a request is presented.
        if (v.eMr) begin
            check({v.nm, ".mem_wr"},    32'(bus.mem_wr),    32'(v.eMw));
            check({v.nm, ".mem_wstrb"}, 32'(bus.mem_wstrb), 32'(v.eMs));
            check({v.nm, ".mem_addr"},  bus.mem_addr,       v.eMa);
            check({v.nm, ".mem_wdata"}, bus.mem_wdata,      v.eMd);
        end
    endtask

    initial begin
        string seq;
        int    both;

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //              name          ir ia            dr dw ds    da            dd            mao mdo mr             eIa eDa eId eDd eMr eMw eMs   eMa           eMd           eB eIr           eDr
        vecs.push_back(mk("fetch_grant", 1, 32'hBFC00000, 0, 0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 0, 0, 4'h0, 32'h0,        32'h0,        0, 32'h0,        32'h0));
        vecs.push_back(mk("fetch_addr",  0, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0,        1, 0, 32'h0,        0, 0, 0, 0, 1, 0, 4'h0, 32'hBFC00000, 32'h0,        1, 32'h0,        32'h0));
        vecs.push_back(mk("fetch_wait",  0, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 4'h0, 32'h0,        32'h0,        1, 32'h0,        32'h0));
        vecs.push_back(mk("fetch_mdok",  0, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0,        0, 1, 32'h3C080001, 0, 0, 0, 0, 0, 0, 4'h0, 32'h0,        32'h0,        1, 32'h0,        32'h0));
        vecs.push_back(mk("fetch_dok",   0, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 1, 0, 0, 0, 4'h0, 32'h0,        32'h0,        0, 32'h3C080001, 32'h0));
        vecs.push_back(mk("fetch_hold",  0, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 4'h0, 32'h0,        32'h0,        0, 32'h3C080001, 32'h0));
        vecs.push_back(mk("both_req",    1, 32'h00000100, 1, 1, 4'hF, 32'h1FC00010, 32'hDEADBEEF, 0, 0, 32'h0,        0, 1, 0, 0, 0, 0, 4'h0, 32'h0,        32'h0,        0, 32'h3C080001, 32'h0));
        vecs.push_back(mk("wr_addr",     1, 32'h00000100, 0, 0, 4'h0, 32'h0,        32'h0,        1, 0, 32'h0,        0, 0, 0, 0, 1, 1, 4'hF, 32'h1FC00010, 32'hDEADBEEF, 1, 32'h3C080001, 32'h0));
        vecs.push_back(mk("wr_mdok",     1, 32'h00000100, 0, 0, 4'h0, 32'h0,        32'h0,        0, 1, 32'hAAAAAAAA, 0, 0, 0, 0, 0, 0, 4'h0, 32'h0,        32'h0,        1, 32'h3C080001, 32'h0));
        vecs.push_back(mk("wr_dok_ig",   1, 32'h00000100, 0, 0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        1, 0, 0, 1, 0, 0, 4'h0, 32'h0,        32'h0,        0, 32'h3C080001, 32'h0));
        vecs.push_back(mk("inst_comb",   0, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0,        1, 1, 32'h11112222, 0, 0, 0, 0, 1, 0, 4'h0, 32'h00000100, 32'h0,        1, 32'h3C080001, 32'h0));
        vecs.push_back(mk("inst_dok",    0, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 1, 0, 0, 0, 4'h0, 32'h0,        32'h0,        0, 32'h11112222, 32'h0));
        vecs.push_back(mk("rd_grant",    0, 32'h0,        1, 0, 4'hF, 32'h80000040, 32'h0,        0, 0, 32'h0,        0, 1, 0, 0, 0, 0, 4'h0, 32'h0,        32'h0,        0, 32'h11112222, 32'h0));
        vecs.push_back(mk("rd_comb",     0, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0,        1, 1, 32'h12345678, 0, 0, 0, 0, 1, 0, 4'h0, 32'h80000040, 32'h0,        1, 32'h11112222, 32'h0));
        vecs.push_back(mk("rd_dok",      0, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 0, 1, 0, 0, 4'h0, 32'h0,        32'h0,        0, 32'h11112222, 32'h12345678));
        vecs.push_back(mk("idle_stray",  0, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0,        1, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 4'h0, 32'h0,        32'h0,        0, 32'h11112222, 32'h12345678));
        vecs.push_back(mk("idle_after",  0, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 4'h0, 32'h0,        32'h0,        0, 32'h11112222, 32'h12345678));

        // reset state
        repeat (2) @(negedge clk);
        checkAllZero("reset_outputs");
        @(posedge clk); #1 resetn = 1'b1;

        foreach (vecs[i]) applyRow(vecs[i]);

        // Starvation: fetch held pending, data always re-requesting, memory
        // completing every request in the accept cycle.
        seq  = "";
        both = 0;
        @(posedge clk); #1;
        drive(1, 32'h00000200, 1, 0, 4'h0, 32'h00000300, 32'h0, 1, 1, 32'h0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.inst_addr_ok && bus.data_addr_ok) both++;
            if (bus.data_addr_ok)      seq = {seq, "D"};
            else if (bus.inst_addr_ok) seq = {seq, "I"};
        end
        checks++;
        if (seq != "DDDDIDDDDI") begin
            errors++;
            $display("FAIL starve_order: got %s expected DDDDIDDDDI", seq);
        end
        check("starve_both_addr_ok", 32'(both), 32'h0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset while a read is waiting in DATA.
        @(posedge clk); #1;
        drive(0, 0, 1, 0, 4'h0, 32'h00000400, 32'h0, 0, 0, 0);
        @(negedge clk); check("rst_rd_grant", 32'(bus.data_addr_ok), 32'h1);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0);
        @(negedge clk); check("rst_rd_memreq", 32'(bus.mem_req), 32'h1);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); check("rst_in_data_busy", 32'(bus.busy), 32'h1);
        @(posedge clk); #1 resetn = 1'b0;
        @(negedge clk); checkAllZero("rst_mid_outputs");
        @(posedge clk); #1 resetn = 1'b1;
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D);
        @(negedge clk); check("rst_late_mdok_busy", 32'(bus.busy), 32'h0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkAllZero("rst_late_mdok_outputs");
        @(posedge clk); #1;
        drive(1, 32'hBFC00004, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); check("rst_next_grant", 32'(bus.inst_addr_ok), 32'h1);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h24020007);
        @(negedge clk);
        check("rst_next_memreq", 32'(bus.mem_req), 32'h1);
        check("rst_next_memaddr", bus.mem_addr, 32'hBFC00004);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rst_next_dok", 32'(bus.inst_data_ok), 32'h1);
        check("rst_next_rdata", bus.inst_rdata, 32'h24020007);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
